io_timer: RTL and testbench

//  Memory-mapped 16-bit timer/compare peripheral; the responder on the CPU data-memory/IO bus.

---
 rtl/io_timer_pkg.sv | 13 +
 rtl/io_timer_if.sv | 12 +
 rtl/io_prescaler.sv | 17 +
 rtl/io_timer.sv | 105 ++++++++++
 tb/tb_io_timer.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/io_timer_pkg.sv
// io_timer_pkg: register offsets and CTRL/STATUS bit positions shared by the timer files
package io_timer_pkg;
    typedef enum logic [2:0] {
        OFF_CTRL, OFF_PRESC, OFF_CNT_L, OFF_CNT_H,
        OFF_CMP_L, OFF_CMP_H, OFF_STATUS, OFF_RSVD
    } reg_off_e;
    localparam int CTRL_EN = 0;
    localparam int CTRL_IRQ_EN = 1;
    localparam int CTRL_ONE_SHOT = 2;
    localparam int CTRL_CLR_ON_MATCH = 3;
    localparam int ST_MATCH = 0;
    localparam int ST_OVF = 1;
endpackage

// File: rtl/io_timer_if.sv
// io_timer_if: CPU data-memory/IO bus plus interrupt lines as seen by the timer
interface io_timer_if;
    logic [15:0] addr;
    logic [7:0] din;
    logic [7:0] dout;
    logic wr_en;
    logic rd_en;
    logic irq;
    logic irq_clr;
    modport master(output addr, din, wr_en, rd_en, irq_clr, input dout, irq);
    modport slave(input addr, din, wr_en, rd_en, irq_clr, output dout, irq);
endinterface

// File: rtl/io_prescaler.sv
// io_prescaler: divides enabled clocks by div+1, tick on the clock where the count wraps
module io_prescaler (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       clr,
    input  logic [7:0] div,
    output logic       tick
);
    logic [7:0] cnt;
    assign tick = en && cnt == div;
    // count while enabled, wrap on tick; clr restarts the divide period
    always_ff @(posedge clk or posedge reset)
        if (reset) cnt <= '0;
        else if (clr) cnt <= '0;
        else if (en) cnt <= tick ? '0 : cnt + 8'd1;
endmodule

// File: rtl/io_timer.sv
// io_timer: memory-mapped 16-bit timer/compare peripheral; `TIMER_PWM_EN adds pwm_out
module io_timer
    import io_timer_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR = 16'h1010
) (
    input logic clk,
    input logic reset,
    io_timer_if.slave bus
`ifdef TIMER_PWM_EN
    ,
    output logic pwm_out
`endif
);
    logic [3:0] ctrl, ctrl_n;
    logic [7:0] presc, rd_shadow, wr_shadow, rd_data;
    logic [15:0] count, count_n, cmp;
    logic match, ovf, match_n, ovf_n, set_match, set_ovf, tick, sel, rd, wr;
    reg_off_e off;

    assign sel = bus.addr[15:3] == BASE_ADDR[15:3];
    assign off = reg_off_e'(bus.addr[2:0]);
    assign rd = sel && bus.rd_en;
    assign wr = sel && bus.wr_en;

    io_prescaler u_prescaler (
        .clk  (clk),
        .reset(reset),
        .en   (ctrl[CTRL_EN]),
        .clr  (wr && (off == OFF_CNT_L || (off == OFF_CTRL && !bus.din[CTRL_EN]))),
        .div  (presc),
        .tick (tick)
    );

    // read mux over the pre-write register values
    always_comb begin
        rd_data = '0;
        case (off)
            OFF_CTRL:   rd_data = {4'h0, ctrl};
            OFF_PRESC:  rd_data = presc;
            OFF_CNT_L:  rd_data = count[7:0];
            OFF_CNT_H:  rd_data = rd_shadow;
            OFF_CMP_L:  rd_data = cmp[7:0];
            OFF_CMP_H:  rd_data = cmp[15:8];
            OFF_STATUS: rd_data = {6'h0, ovf, match};
            default:    rd_data = '0;
        endcase
    end

    // count/compare step: a CPU write to COUNT overrides any tick; flag sets beat clears
    always_comb begin
        count_n = count;
        ctrl_n = ctrl;
        set_match = 1'b0;
        set_ovf = 1'b0;
        if (wr && off == OFF_CNT_L) count_n = {wr_shadow, bus.din};
        else if (tick) begin
            if (count == cmp) begin
                set_match = 1'b1;
                count_n = ctrl[CTRL_CLR_ON_MATCH] ? '0 : count + 16'd1;
                if (ctrl[CTRL_ONE_SHOT]) ctrl_n[CTRL_EN] = 1'b0;
            end else if (count == 16'hFFFF) begin
                count_n = '0;
                set_ovf = 1'b1;
            end else count_n = count + 16'd1;
        end
        if (wr && off == OFF_CTRL) ctrl_n = bus.din[3:0];
        match_n = set_match || (match && !(bus.irq_clr || (wr && off == OFF_STATUS && bus.din[ST_MATCH])));
        ovf_n = set_ovf || (ovf && !(bus.irq_clr || (wr && off == OFF_STATUS && bus.din[ST_OVF])));
    end

    // register file, flags, latched read data and interrupt level
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            ctrl <= '0;
            presc <= '0;
            count <= '0;
            cmp <= '0;
            match <= 1'b0;
            ovf <= 1'b0;
            rd_shadow <= '0;
            wr_shadow <= '0;
            bus.dout <= '0;
            bus.irq <= 1'b0;
        end else begin
            ctrl <= ctrl_n;
            count <= count_n;
            match <= match_n;
            ovf <= ovf_n;
            bus.irq <= (match_n || ovf_n) && ctrl_n[CTRL_IRQ_EN];
            bus.dout <= rd ? rd_data : '0;
            if (rd && off == OFF_CNT_L) rd_shadow <= count[15:8];
            if (wr && off == OFF_PRESC) presc <= bus.din;
            if (wr && off == OFF_CNT_H) wr_shadow <= bus.din;
            if (wr && off == OFF_CMP_L) cmp[7:0] <= bus.din;
            if (wr && off == OFF_CMP_H) cmp[15:8] <= bus.din;
        end

`ifdef TIMER_PWM_EN
    // PWM high while counting below the compare value
    always_ff @(posedge clk or posedge reset)
        if (reset) pwm_out <= 1'b0;
        else pwm_out <= ctrl[CTRL_EN] && count < cmp;
`endif
endmodule

// File: tb/tb_io_timer.sv
// tb_io_timer: directed scenarios plus randomized bus traffic checked against a cycle model
module tb_io_timer;
    localparam logic [15:0] BASE = 16'h1010;
    logic clk = 1'b0;
    logic reset;
    int errors = 0;
    int checks = 0;
    int m_ctrl, m_presc, m_cnt, m_cmp, m_match, m_ovf, m_rsh, m_wsh, m_pre, m_dout, m_irq, m_pwm;

    io_timer_if bus();
`ifdef TIMER_PWM_EN
    logic pwm_out;
    io_timer #(.BASE_ADDR(BASE)) dut (.clk(clk), .reset(reset), .bus(bus.slave), .pwm_out(pwm_out));
`else
    io_timer #(.BASE_ADDR(BASE)) dut (.clk(clk), .reset(reset), .bus(bus.slave));
`endif

    always #5 clk = ~clk;

    task automatic model_reset();
        m_ctrl = 0; m_presc = 0; m_cnt = 0; m_cmp = 0; m_match = 0; m_ovf = 0;
        m_rsh = 0; m_wsh = 0; m_pre = 0; m_dout = 0; m_irq = 0; m_pwm = 0;
    endtask

    function automatic int model_read(int off);
        case (off)
            0: return m_ctrl;
            1: return m_presc;
            2: return m_cnt % 256;
            3: return m_rsh;
            4: return m_cmp % 256;
            5: return m_cmp / 256;
            6: return m_ovf * 2 + m_match;
            default: return 0;
        endcase
    endfunction

    // one clock of the timer's documented behaviour, from the inputs present before the edge
    task automatic model_step();
        int off, d, w, r, en, tick, n_ctrl, n_cnt, set_m, set_o, clr_m, clr_o;
        off = int'(bus.addr[2:0]);
        d = int'(bus.din);
        w = (bus.addr[15:3] == BASE[15:3] && bus.wr_en) ? 1 : 0;
        r = (bus.addr[15:3] == BASE[15:3] && bus.rd_en) ? 1 : 0;
        en = m_ctrl % 2;
        tick = (en == 1 && m_pre == m_presc) ? 1 : 0;
        m_pwm = (en == 1 && m_cnt < m_cmp) ? 1 : 0;
        m_dout = (r == 1) ? model_read(off) : 0;
        if (r == 1 && off == 2) m_rsh = m_cnt / 256;
        n_ctrl = m_ctrl;
        n_cnt = m_cnt;
        set_m = 0;
        set_o = 0;
        if (w == 1 && off == 2) n_cnt = m_wsh * 256 + d;
        else if (tick == 1) begin
            if (m_cnt == m_cmp) begin
                set_m = 1;
                n_cnt = ((m_ctrl / 8) % 2 == 1) ? 0 : (m_cnt + 1) % 65536;
                if ((m_ctrl / 4) % 2 == 1) n_ctrl = m_ctrl - 1;
            end else if (m_cnt == 65535) begin
                set_o = 1;
                n_cnt = 0;
            end else n_cnt = m_cnt + 1;
        end
        if (w == 1 && off == 0) n_ctrl = d % 16;
        if (w == 1 && off == 1) m_presc = d;
        if (w == 1 && off == 3) m_wsh = d;
        if (w == 1 && off == 4) m_cmp = (m_cmp / 256) * 256 + d;
        if (w == 1 && off == 5) m_cmp = d * 256 + m_cmp % 256;
        if (w == 1 && (off == 2 || (off == 0 && d % 2 == 0))) m_pre = 0;
        else if (en == 1) m_pre = (tick == 1) ? 0 : m_pre + 1;
        clr_m = (bus.irq_clr || (w == 1 && off == 6 && d % 2 == 1)) ? 1 : 0;
        clr_o = (bus.irq_clr || (w == 1 && off == 6 && (d / 2) % 2 == 1)) ? 1 : 0;
        m_match = (set_m == 1 || (m_match == 1 && clr_m == 0)) ? 1 : 0;
        m_ovf = (set_o == 1 || (m_ovf == 1 && clr_o == 0)) ? 1 : 0;
        m_ctrl = n_ctrl;
        m_cnt = n_cnt;
        m_irq = ((m_match == 1 || m_ovf == 1) && (m_ctrl / 2) % 2 == 1) ? 1 : 0;
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_op(input int off, input int d, input bit w, input bit r);
        bus.addr = BASE + 16'(off);
        bus.din = 8'(d);
        bus.wr_en = w;
        bus.rd_en = r;
        step();
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
    endtask

    task automatic wr(input int off, input int d);
        bus_op(off, d, 1'b1, 1'b0);
    endtask

    task automatic rd(input int off, output logic [7:0] v);
        bus_op(off, 0, 1'b0, 1'b1);
        v = bus.dout;
    endtask

    task automatic test_reset();
        logic [7:0] v;
        for (int i = 0; i < 8; i++) begin
            rd(i, v);
            checks++; if (v !== 8'h00) begin errors++; $display("FAIL reset_read_off%0d: got %h want 00", i, v); end
        end
        checks++; if (bus.irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b want 0", bus.irq); end
    endtask

    task automatic test_basic_match();
        logic [7:0] v;
        wr(1, 0); wr(4, 5); wr(5, 0); wr(6, 3); wr(0, 3);
        repeat (5) step();
        checks++; if (bus.irq !== 1'b0) begin errors++; $display("FAIL match_early: irq got %b want 0", bus.irq); end
        step();
        checks++; if (bus.irq !== 1'b1) begin errors++; $display("FAIL match_irq: irq got %b want 1", bus.irq); end
        rd(6, v);
        checks++; if (v !== 8'h01) begin errors++; $display("FAIL match_status: got %h want 01", v); end
        bus.irq_clr = 1'b1;
        step();
        bus.irq_clr = 1'b0;
        checks++; if (bus.irq !== 1'b0) begin errors++; $display("FAIL match_irq_clr: irq got %b want 0", bus.irq); end
        wr(0, 0);
    endtask

    task automatic test_overflow();
        logic [7:0] v;
        wr(3, 8'hFF); wr(2, 8'hFE); wr(4, 8'h10); wr(5, 0); wr(0, 3);
        step();
        wr(0, 2);
        rd(2, v);
        checks++; if (v !== 8'h00) begin errors++; $display("FAIL ovf_cnt_l: got %h want 00", v); end
        rd(3, v);
        checks++; if (v !== 8'h00) begin errors++; $display("FAIL ovf_cnt_h: got %h want 00", v); end
        rd(6, v);
        checks++; if (v !== 8'h02) begin errors++; $display("FAIL ovf_status: got %h want 02", v); end
        checks++; if (bus.irq !== 1'b1) begin errors++; $display("FAIL ovf_irq: got %b want 1", bus.irq); end
        wr(6, 2);
        rd(6, v);
        checks++; if (v !== 8'h00) begin errors++; $display("FAIL ovf_w1c: got %h want 00", v); end
        checks++; if (bus.irq !== 1'b0) begin errors++; $display("FAIL ovf_w1c_irq: got %b want 0", bus.irq); end
    endtask

    task automatic test_atomic();
        logic [7:0] v;
        wr(3, 8'h12); wr(2, 8'hFF); wr(0, 1);
        rd(2, v);
        checks++; if (v !== 8'hFF) begin errors++; $display("FAIL atomic_lo: got %h want ff", v); end
        wr(0, 0);
        rd(3, v);
        checks++; if (v !== 8'h12) begin errors++; $display("FAIL atomic_hi: got %h want 12", v); end
        rd(2, v);
        checks++; if (v !== 8'h01) begin errors++; $display("FAIL atomic_lo2: got %h want 01", v); end
        rd(3, v);
        checks++; if (v !== 8'h13) begin errors++; $display("FAIL atomic_hi2: got %h want 13", v); end
    endtask

    task automatic test_oneshot();
        logic [7:0] v;
        wr(3, 0); wr(2, 0); wr(1, 3); wr(4, 2); wr(5, 0); wr(6, 3); wr(0, 8'h0F);
        repeat (11) step();
        checks++; if (bus.irq !== 1'b0) begin errors++; $display("FAIL oneshot_early: irq got %b want 0", bus.irq); end
        step();
        checks++; if (bus.irq !== 1'b1) begin errors++; $display("FAIL oneshot_irq: irq got %b want 1", bus.irq); end
        rd(0, v);
        checks++; if (v !== 8'h0E) begin errors++; $display("FAIL oneshot_ctrl: got %h want 0e", v); end
        rd(2, v);
        checks++; if (v !== 8'h00) begin errors++; $display("FAIL oneshot_cnt_l: got %h want 00", v); end
        rd(3, v);
        checks++; if (v !== 8'h00) begin errors++; $display("FAIL oneshot_cnt_h: got %h want 00", v); end
        wr(6, 3); wr(1, 0); wr(0, 0);
    endtask

    task automatic test_collision();
        logic [7:0] v;
        wr(3, 0); wr(2, 0); wr(4, 1); wr(5, 0); wr(6, 3); wr(0, 3);
        wr(3, 8'hAB);
        wr(2, 8'hCD);
        wr(0, 2);
        rd(6, v);
        checks++; if (v !== 8'h00) begin errors++; $display("FAIL collide_no_flag: got %h want 00", v); end
        checks++; if (bus.irq !== 1'b0) begin errors++; $display("FAIL collide_irq: got %b want 0", bus.irq); end
        rd(2, v);
        checks++; if (v !== 8'hCE) begin errors++; $display("FAIL collide_cnt_l: got %h want ce", v); end
        rd(3, v);
        checks++; if (v !== 8'hAB) begin errors++; $display("FAIL collide_cnt_h: got %h want ab", v); end
        wr(3, 0); wr(2, 0); wr(4, 3); wr(6, 3); wr(0, 3);
        repeat (3) step();
        bus.irq_clr = 1'b1;
        step();
        bus.irq_clr = 1'b0;
        checks++; if (bus.irq !== 1'b1) begin errors++; $display("FAIL set_beats_clr: irq got %b want 1", bus.irq); end
        rd(6, v);
        checks++; if (v !== 8'h01) begin errors++; $display("FAIL set_beats_clr_status: got %h want 01", v); end
        bus_op(4, 8'h55, 1'b1, 1'b1);
        checks++; if (bus.dout !== 8'h03) begin errors++; $display("FAIL rw_same_cycle: got %h want 03", bus.dout); end
        rd(4, v);
        checks++; if (v !== 8'h55) begin errors++; $display("FAIL rw_written: got %h want 55", v); end
        wr(0, 0); wr(6, 3);
    endtask

    task automatic test_reset_midcount();
        logic [7:0] v;
        wr(6, 3); wr(4, 0); wr(5, 0); wr(3, 0); wr(2, 0); wr(0, 3);
        step();
        rd(0, v);
        checks++; if (v !== 8'h03 || bus.irq !== 1'b1) begin errors++; $display("FAIL pre_reset: ctrl %h irq %b want 03 1", v, bus.irq); end
        #1 reset = 1'b1;
        #1 model_reset();
        checks++; if (bus.dout !== 8'h00 || bus.irq !== 1'b0) begin errors++; $display("FAIL async_reset: dout %h irq %b want 00 0", bus.dout, bus.irq); end
        @(negedge clk);
        reset = 1'b0;
        repeat (3) step();
        rd(2, v);
        checks++; if (v !== 8'h00) begin errors++; $display("FAIL reset_holds_count: got %h want 00", v); end
        rd(0, v);
        checks++; if (v !== 8'h00) begin errors++; $display("FAIL reset_ctrl: got %h want 00", v); end
    endtask

`ifdef TIMER_PWM_EN
    task automatic test_pwm();
        wr(3, 0); wr(2, 0); wr(1, 0); wr(4, 3); wr(5, 0); wr(6, 3); wr(0, 8'h09);
        for (int i = 0; i < 8; i++) begin
            step();
            checks++; if (pwm_out !== (i % 4 != 3)) begin errors++; $display("FAIL pwm_cycle%0d: got %b want %b", i, pwm_out, i % 4 != 3); end
        end
        wr(0, 0); wr(6, 3);
    endtask
`endif

    task automatic test_random();
        int off;
        for (int n = 0; n < 800; n++) begin
            off = $urandom_range(0, 7);
            bus.addr = ($urandom_range(0, 9) == 0) ? 16'($urandom) : BASE + 16'(off);
            bus.wr_en = ($urandom_range(0, 2) == 0);
            bus.rd_en = ($urandom_range(0, 1) == 1);
            bus.irq_clr = ($urandom_range(0, 19) == 0);
            case (off)
                1: bus.din = 8'($urandom_range(0, 3));
                2, 4: bus.din = 8'($urandom_range(0, 15));
                3, 5: bus.din = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom_range(0, 1));
                default: bus.din = 8'($urandom);
            endcase
            step();
            checks++; if (bus.dout !== m_dout[7:0]) begin errors++; $display("FAIL rand_dout@%0d: got %h want %h", n, bus.dout, m_dout[7:0]); end
            checks++; if (bus.irq !== m_irq[0]) begin errors++; $display("FAIL rand_irq@%0d: got %b want %b", n, bus.irq, m_irq[0]); end
`ifdef TIMER_PWM_EN
            checks++; if (pwm_out !== m_pwm[0]) begin errors++; $display("FAIL rand_pwm@%0d: got %b want %b", n, pwm_out, m_pwm[0]); end
`endif
        end
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        bus.irq_clr = 1'b0;
    endtask

    initial begin
        bus.addr = '0;
        bus.din = '0;
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        bus.irq_clr = 1'b0;
        reset = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        test_reset();
        test_basic_match();
        test_overflow();
        test_atomic();
        test_oneshot();
        test_collision();
        test_reset_midcount();
`ifdef TIMER_PWM_EN
        test_pwm();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
